// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums K-tile rows from the systolic array into a row
// buffer with per-column saturation, then drains finished rows to Normalization.

module psum_lane #(
    parameter int IN_WIDTH  = 24,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 first,
    input  logic [IN_WIDTH-1:0]  in_val,
    input  logic [ACC_WIDTH-1:0] acc_val,
    output logic [ACC_WIDTH-1:0] res_val
);
    localparam logic signed [ACC_WIDTH:0] MAX_V = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MIN_V = {2'b11, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum;

    // One guard bit above ACC_WIDTH is enough to detect overflow of a single add.
    always_comb begin
        sum = $signed({{(ACC_WIDTH+1-IN_WIDTH){in_val[IN_WIDTH-1]}}, in_val});
        if (!first) sum = sum + $signed({acc_val[ACC_WIDTH-1], acc_val});
        if (sum > MAX_V)      res_val = MAX_V[ACC_WIDTH-1:0];
        else if (sum < MIN_V) res_val = MIN_V[ACC_WIDTH-1:0];
        else                  res_val = sum[ACC_WIDTH-1:0];
    end
endmodule

module psum_accumulator #(
    parameter  int IN_WIDTH  = 24,
    parameter  int ACC_WIDTH = 32,
    parameter  int SA_LENGTH = 256,
    parameter  int DEPTH     = 256,
    localparam int RW        = $clog2(DEPTH+1)
) (
    input  logic                                Clk,
    input  logic                                Rst_n,
    input  logic                                Start,
    input  logic [RW-1:0]                       NumRows,
    input  logic [15:0]                         NumPasses,
    input  logic                                InValid,
    output logic                                InReady,
    input  logic [SA_LENGTH-1:0][IN_WIDTH-1:0]  In,
    output logic                                OutValid,
    input  logic                                OutReady,
    output logic [SA_LENGTH-1:0][ACC_WIDTH-1:0] Out,
    output logic                                Busy,
    output logic                                Done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d, num_rows_q, num_rows_d, rows_clamped;
    logic [15:0]   pass_q, pass_d, num_passes_q, num_passes_d;
    logic          in_fire, out_fire, last_row, first_pass;
    logic [AW-1:0] row_idx;

    logic [SA_LENGTH-1:0][ACC_WIDTH-1:0] buf_q [DEPTH];
    logic [SA_LENGTH-1:0][ACC_WIDTH-1:0] wr_row, rd_row;

    assign row_idx      = row_q[AW-1:0];
    assign rd_row       = buf_q[row_idx];
    assign rows_clamped = (NumRows > RW'(DEPTH)) ? RW'(DEPTH) : NumRows;
    assign last_row     = (row_q == num_rows_q - RW'(1));
    assign first_pass   = (pass_q == 16'd0);
    assign in_fire      = (state_q == ACCUM) && InValid;
    assign out_fire     = (state_q == DRAIN) && OutReady;

    for (genvar c = 0; c < SA_LENGTH; c++) begin : g_lane
        psum_lane #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
            .first   (first_pass),
            .in_val  (In[c]),
            .acc_val (rd_row[c]),
            .res_val (wr_row[c])
        );
    end

    // Buffer holds data only; it is fully rewritten by pass 0 of every job.
    always_ff @(posedge Clk) begin
        if (in_fire) buf_q[row_idx] <= wr_row;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            pass_q       <= '0;
            num_rows_q   <= '0;
            num_passes_q <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            pass_q       <= pass_d;
            num_rows_q   <= num_rows_d;
            num_passes_q <= num_passes_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        pass_d       = pass_q;
        num_rows_d   = num_rows_q;
        num_passes_d = num_passes_q;
        case (state_q)
            IDLE: if (Start) begin
                num_rows_d   = rows_clamped;
                num_passes_d = NumPasses;
                row_d        = '0;
                pass_d       = '0;
                state_d      = (rows_clamped == '0 || NumPasses == 16'd0) ? DONE : ACCUM;
            end
            ACCUM: if (in_fire) begin
                if (last_row) begin
                    row_d  = '0;
                    pass_d = pass_q + 16'd1;
                    if (pass_q == num_passes_q - 16'd1) state_d = DRAIN;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DRAIN: if (out_fire) begin
                row_d = row_q + RW'(1);
                if (last_row) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        InReady  = (state_q == ACCUM);
        OutValid = (state_q == DRAIN);
        Busy     = (state_q != IDLE);
        Done     = (state_q == DONE);
        Out      = OutValid ? rd_row : '0;
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator, checked against an integer row model
// that accumulates with clamping after every pass.

module tb_psum_accumulator;
    localparam int IW  = 8;
    localparam int AWD = 10;
    localparam int SA  = 4;
    localparam int DEP = 8;
    localparam int RW  = $clog2(DEP+1);
    localparam int MAXV = (1 << (AWD-1)) - 1;
    localparam int MINV = -(1 << (AWD-1));

    typedef logic [SA-1:0][IW-1:0]  irow_t;
    typedef logic [SA-1:0][AWD-1:0] orow_t;

    logic          Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, InValid = 1'b0, OutReady = 1'b0;
    logic [RW-1:0] NumRows = '0;
    logic [15:0]   NumPasses = '0;
    irow_t         In = '0;
    orow_t         Out;
    logic          InReady, OutValid, Busy, Done;

    int    checks = 0, failures = 0;
    irow_t stim [0:7][0:7];
    orow_t got[$], exp_q[$];
    int    done_lat, in2out_lat, stall_err, zero_err, ov_seen, timeout, done_after;

    psum_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AWD), .SA_LENGTH(SA), .DEPTH(DEP)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .NumRows(NumRows), .NumPasses(NumPasses),
        .InValid(InValid), .InReady(InReady), .In(In), .OutValid(OutValid),
        .OutReady(OutReady), .Out(Out), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    function automatic int clampv(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    task automatic build_expected(input int nr, input int np);
        int acc [0:7][0:SA-1];
        int nre;
        orow_t o;
        nre = (nr > DEP) ? DEP : nr;
        exp_q.delete();
        if (nre == 0 || np == 0) return;
        for (int p = 0; p < np; p++)
            for (int r = 0; r < nre; r++)
                for (int c = 0; c < SA; c++) begin
                    int x;
                    x = int'($signed(stim[p][r][c]));
                    acc[r][c] = (p == 0) ? x : clampv(acc[r][c] + x);
                end
        for (int r = 0; r < nre; r++) begin
            for (int c = 0; c < SA; c++) o[c] = AWD'(acc[r][c]);
            exp_q.push_back(o);
        end
    endtask

    task automatic set_row(input int p, input int r, input int a, input int b, input int c, input int d);
        stim[p][r][0] = IW'(a);
        stim[p][r][1] = IW'(b);
        stim[p][r][2] = IW'(c);
        stim[p][r][3] = IW'(d);
    endtask

    task automatic fill_random();
        for (int p = 0; p < 8; p++)
            for (int r = 0; r < 8; r++) stim[p][r] = irow_t'($urandom);
    endtask

    task automatic load_basic();
        for (int p = 0; p < 2; p++) begin
            set_row(p, 0, 1, 2, 3, 4);
            set_row(p, 1, -1, -1, -1, -1);
            set_row(p, 2, 0, 0, 0, 5);
        end
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,..., 2 random
    task automatic run_job(input int nr, input int np, input int vprob, input int rmode,
                           input bit junk, input bit poke);
        int nre, total, beat, cyc, k, last_hs, last_in, first_ov;
        bit prev_stall;
        orow_t prev_out;
        nre = (nr > DEP) ? DEP : nr;
        total = (nre == 0) ? 0 : nre * np;
        beat = 0; cyc = 0; k = 0; last_hs = -1; last_in = -1; first_ov = -1;
        prev_stall = 1'b0; prev_out = '0;
        got.delete();
        stall_err = 0; zero_err = 0; ov_seen = 0; timeout = 0; done_lat = -1; in2out_lat = -1;
        @(negedge Clk);
        NumRows = RW'(nr); NumPasses = 16'(np); Start = 1'b1;
        forever begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
            if (cyc > 3000) begin timeout = 1; break; end
            if (prev_stall && (!OutValid || Out !== prev_out)) stall_err++;
            if (!OutValid && Out !== '0) zero_err++;
            if (OutValid) begin ov_seen++; if (first_ov < 0) first_ov = cyc; end
            if (Done) begin done_lat = (last_hs >= 0) ? cyc - last_hs : cyc; break; end
            if (InReady && beat < total) begin
                In = stim[beat / nre][beat % nre];
                InValid = ($urandom_range(99) < vprob);
                if (InValid) begin beat++; last_in = cyc; end
            end else begin
                InValid = junk;
                In = irow_t'($urandom);
            end
            if (poke && InReady) begin
                Start = 1'b1; NumRows = RW'(1); NumPasses = 16'd1;
            end
            if (OutValid) begin
                case (rmode)
                    0:       OutReady = 1'b1;
                    1:       OutReady = (k % 3 == 0);
                    default: OutReady = 1'($urandom_range(1));
                endcase
                k++;
                if (OutReady) begin got.push_back(Out); last_hs = cyc; end
                prev_stall = !OutReady;
                prev_out = Out;
            end else begin
                OutReady = 1'($urandom_range(1));
                prev_stall = 1'b0;
            end
        end
        if (last_in >= 0 && first_ov >= 0) in2out_lat = first_ov - last_in;
        InValid = 1'b0; OutReady = 1'b0; Start = 1'b0;
        @(negedge Clk);
        done_after = int'({Done, Busy});
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({InReady, OutValid, Busy, Done} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {InReady, OutValid, Busy, Done});
        end
        checks++;
        if (Out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", Out); end
        @(negedge Clk); Rst_n = 1'b1;
        load_basic();
        @(negedge Clk); NumRows = RW'(3); NumPasses = 16'd2; Start = 1'b1;
        @(negedge Clk); Start = 1'b0; InValid = 1'b1; In = stim[0][0];
        @(negedge Clk); In = stim[0][1];
        checks++;
        if ({InReady, Busy} !== 2'b11) begin
            failures++; $display("FAIL accum_entry got=%b exp=11", {InReady, Busy});
        end
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if ({InReady, Busy, OutValid, Done} !== 4'b0000) begin
            failures++; $display("FAIL midjob_reset got=%b exp=0000", {InReady, Busy, OutValid, Done});
        end
        @(negedge Clk); Rst_n = 1'b1; InValid = 1'b0;
        build_expected(3, 2);
        run_job(3, 2, 100, 0, 1'b0, 1'b0);
        checks++;
        if (got.size() !== exp_q.size() || timeout != 0) begin
            failures++; $display("FAIL restart_count got=%0d exp=%0d", got.size(), exp_q.size());
        end else for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL restart_row%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_basic();
        orow_t r0;
        load_basic();
        build_expected(3, 2);
        run_job(3, 2, 100, 0, 1'b0, 1'b0);
        checks++;
        if (got.size() !== 3 || timeout != 0) begin
            failures++; $display("FAIL basic_count got=%0d exp=3", got.size());
        end else for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL basic_row%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        r0[0] = AWD'(2); r0[1] = AWD'(4); r0[2] = AWD'(6); r0[3] = AWD'(8);
        checks++;
        if (got.size() > 0 && got[0] !== r0) begin failures++; $display("FAIL basic_row0_const got=%h exp=%h", got[0], r0); end
        checks++;
        if (done_lat != 1) begin failures++; $display("FAIL basic_done_latency got=%0d exp=1", done_lat); end
        checks++;
        if (in2out_lat != 1) begin failures++; $display("FAIL basic_in2out_latency got=%0d exp=1", in2out_lat); end
        checks++;
        if (done_after != 0) begin failures++; $display("FAIL basic_done_pulse got=%0d exp=0", done_after); end
        checks++;
        if (zero_err != 0) begin failures++; $display("FAIL basic_out_zero got=%0d exp=0", zero_err); end
    endtask

    task automatic test_saturation();
        orow_t want;
        for (int p = 0; p < 5; p++) set_row(p, 0, 127, -128, 100, 0);
        build_expected(1, 5);
        run_job(1, 5, 100, 0, 1'b0, 1'b0);
        want[0] = AWD'(511); want[1] = AWD'(-512); want[2] = AWD'(500); want[3] = AWD'(0);
        checks++;
        if (got.size() !== 1 || got[0] !== want) begin
            failures++; $display("FAIL sat_const got_n=%0d got=%h exp=%h", got.size(), (got.size() > 0) ? got[0] : '0, want);
        end
        checks++;
        if (exp_q.size() !== 1 || exp_q[0] !== want) begin
            failures++; $display("FAIL sat_model got=%h exp=%h", exp_q[0], want);
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        build_expected(5, 2);
        run_job(5, 2, 100, 1, 1'b0, 1'b0);
        checks++;
        if (got.size() !== exp_q.size() || timeout != 0) begin
            failures++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), exp_q.size());
        end else for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp_row%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++;
        if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
        checks++;
        if (done_lat != 1) begin failures++; $display("FAIL bp_done_latency got=%0d exp=1", done_lat); end
    endtask

    task automatic test_degenerate();
        run_job(3, 0, 100, 0, 1'b0, 1'b0);
        checks++;
        if (ov_seen != 0 || got.size() != 0) begin failures++; $display("FAIL zero_pass_outvalid got=%0d exp=0", ov_seen); end
        checks++;
        if (done_lat != 1 || timeout != 0) begin failures++; $display("FAIL zero_pass_done got=%0d exp=1", done_lat); end
        checks++;
        if (done_after != 0) begin failures++; $display("FAIL zero_pass_pulse got=%0d exp=0", done_after); end
        run_job(0, 2, 100, 0, 1'b0, 1'b0);
        checks++;
        if (ov_seen != 0 || done_lat != 1) begin failures++; $display("FAIL zero_rows got_ov=%0d got_lat=%0d exp=0/1", ov_seen, done_lat); end
        load_basic();
        build_expected(3, 2);
        run_job(3, 2, 100, 0, 1'b0, 1'b1);
        checks++;
        if (got.size() !== exp_q.size() || timeout != 0) begin
            failures++; $display("FAIL start_ignored_count got=%0d exp=%0d", got.size(), exp_q.size());
        end else for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL start_ignored_row%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_input_gaps();
        load_basic();
        build_expected(3, 2);
        run_job(3, 2, 50, 0, 1'b1, 1'b0);
        checks++;
        if (got.size() !== exp_q.size() || timeout != 0) begin
            failures++; $display("FAIL gaps_count got=%0d exp=%0d", got.size(), exp_q.size());
        end else for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL gaps_row%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int nr, np;
            nr = $urandom_range(10, 1);
            np = $urandom_range(6, 1);
            fill_random();
            build_expected(nr, np);
            run_job(nr, np, 70, 2, 1'b1, 1'b0);
            checks++;
            if (got.size() !== exp_q.size() || timeout != 0) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, got.size(), exp_q.size());
            end else for (int i = 0; i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_row%0d got=%h exp=%h", t, i, got[i], exp_q[i]); end
            end
            checks++;
            if (stall_err != 0 || zero_err != 0) begin
                failures++; $display("FAIL rand%0d_out_rules got=%0d/%0d exp=0/0", t, stall_err, zero_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_degenerate();
        test_input_gaps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
